imem_dbg_loader: RTL and testbench

IMEM_DBG_LOADER -- requirements
Module: imem_dbg_loader

---
 rtl/imem_dbg_loader_pkg.sv | 36 +++
 rtl/imem_dbg_loader.sv | 205 ++++++++++++++++++++
 tb/tb_imem_dbg_loader.sv | 505 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_dbg_loader_pkg.sv
// Shared definitions for the imem debug-port loader: AHB-Lite encodings,
// the loader FSM state type and a byte-lane merge helper.
// IMEM_DBG_LOADER_READBACK_EN adds the read-back verify states to the enum.
package imem_dbg_loader_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        ADDR,
        DATA,
`ifdef IMEM_DBG_LOADER_READBACK_EN
        DONE,
        RB_ADDR,
        RB_DATA
`else
        DONE
`endif
    } state_e;

    // Replace one little-endian byte lane of a word.
    function automatic logic [31:0] merge_byte(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [7:0]  b);
        logic [31:0] r;
        r = word;
        r[{lane, 3'b000} +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/imem_dbg_loader.sv
// Loads a little-endian byte stream into instruction memory through the
// imem AHB-Lite debug port, one single-beat word write per four bytes.
// Optional feature macro: IMEM_DBG_LOADER_READBACK_EN -- each written word is
// read back from the same address and compared; a mismatch aborts the load.
module imem_dbg_loader
    import imem_dbg_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  word_cnt,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    input  logic [7:0]            byte_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [CNT_WIDTH-1:0]  words_written,
    output logic [ADDR_WIDTH-1:0] imem_dbg_ahb_HADDR,
    output logic                  imem_dbg_ahb_HSEL,
    output logic                  imem_dbg_ahb_HREADY,
    output logic                  imem_dbg_ahb_HWRITE,
    output logic [2:0]            imem_dbg_ahb_HSIZE,
    output logic [2:0]            imem_dbg_ahb_HBURST,
    output logic [3:0]            imem_dbg_ahb_HPROT,
    output logic [1:0]            imem_dbg_ahb_HTRANS,
    output logic                  imem_dbg_ahb_HMASTLOCK,
    output logic [31:0]           imem_dbg_ahb_HWDATA,
    input  logic [31:0]           imem_dbg_ahb_HRDATA,
    input  logic                  imem_dbg_ahb_HREADYOUT,
    input  logic                  imem_dbg_ahb_HRESP
);

    // Word-aligned view of the requested base address.
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   haddr_q;
    logic [31:0]             hwdata_q;
    logic [CNT_WIDTH-1:0]    cnt_q;
    logic [CNT_WIDTH-1:0]    ww_q;
    logic [1:0]              idx_q;
    logic                    err_q;
    logic                    done_q;
    logic                    busy_q;
    logic                    hsel_q;
    logic [1:0]              htrans_q;
    logic                    hwrite_q;
    logic                    byte_ready_q;
    logic                    last_write;

    // The write finishing now is the final word of the load.
    assign last_write = (ww_q + CNT_WIDTH'(1)) == cnt_q;

    // Single-slave port: the bus ready is the slave's own ready.
    assign imem_dbg_ahb_HREADY    = imem_dbg_ahb_HREADYOUT;
    assign imem_dbg_ahb_HSIZE     = HSIZE_WORD;
    assign imem_dbg_ahb_HBURST    = HBURST_SINGLE;
    assign imem_dbg_ahb_HPROT     = HPROT_DEFAULT;
    assign imem_dbg_ahb_HMASTLOCK = 1'b0;
    assign imem_dbg_ahb_HADDR     = haddr_q;
    assign imem_dbg_ahb_HSEL      = hsel_q;
    assign imem_dbg_ahb_HTRANS    = htrans_q;
    assign imem_dbg_ahb_HWRITE    = hwrite_q;
    assign imem_dbg_ahb_HWDATA    = hwdata_q;
    assign byte_ready             = byte_ready_q;
    assign busy                   = busy_q;
    assign done                   = done_q;
    assign err                    = err_q;
    assign words_written          = ww_q;

`ifndef IMEM_DBG_LOADER_READBACK_EN
    // Read data only matters for the verify pass.
    logic unused_hrdata;
    assign unused_hrdata = ^imem_dbg_ahb_HRDATA;
`endif

    // Loader FSM; every bus and handshake output is registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            haddr_q      <= '0;
            hwdata_q     <= '0;
            cnt_q        <= '0;
            ww_q         <= '0;
            idx_q        <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            hsel_q       <= 1'b0;
            htrans_q     <= HTRANS_IDLE;
            hwrite_q     <= 1'b0;
            byte_ready_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        haddr_q <= base_addr & ADDR_MASK;
                        cnt_q   <= word_cnt;
                        ww_q    <= '0;
                        err_q   <= 1'b0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        if (word_cnt == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q      <= COLLECT;
                            byte_ready_q <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (byte_valid && byte_ready_q) begin
                        hwdata_q <= merge_byte(hwdata_q, idx_q, byte_data);
                        idx_q    <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            byte_ready_q <= 1'b0;
                            state_q      <= ADDR;
                            hsel_q       <= 1'b1;
                            htrans_q     <= HTRANS_NONSEQ;
                            hwrite_q     <= 1'b1;
                        end
                    end
                end
                ADDR: begin
                    if (imem_dbg_ahb_HREADYOUT) begin
                        state_q  <= DATA;
                        hsel_q   <= 1'b0;
                        htrans_q <= HTRANS_IDLE;
                        hwrite_q <= 1'b0;
                    end
                end
                DATA: begin
                    if (imem_dbg_ahb_HREADYOUT) begin
                        if (imem_dbg_ahb_HRESP) begin
                            err_q   <= 1'b1;
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            ww_q <= ww_q + CNT_WIDTH'(1);
`ifdef IMEM_DBG_LOADER_READBACK_EN
                            // Verify the word just written at the same address.
                            state_q  <= RB_ADDR;
                            hsel_q   <= 1'b1;
                            htrans_q <= HTRANS_NONSEQ;
                            hwrite_q <= 1'b0;
`else
                            haddr_q <= haddr_q + ADDR_WIDTH'(4);
                            if (last_write) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q      <= COLLECT;
                                byte_ready_q <= 1'b1;
                            end
`endif
                        end
                    end
                end
`ifdef IMEM_DBG_LOADER_READBACK_EN
                RB_ADDR: begin
                    if (imem_dbg_ahb_HREADYOUT) begin
                        state_q  <= RB_DATA;
                        hsel_q   <= 1'b0;
                        htrans_q <= HTRANS_IDLE;
                    end
                end
                RB_DATA: begin
                    if (imem_dbg_ahb_HREADYOUT) begin
                        if (imem_dbg_ahb_HRESP || (imem_dbg_ahb_HRDATA != hwdata_q)) begin
                            err_q   <= 1'b1;
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            haddr_q <= haddr_q + ADDR_WIDTH'(4);
                            // ww_q already counts the verified word here.
                            if (ww_q == cnt_q) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q      <= COLLECT;
                                byte_ready_q <= 1'b1;
                            end
                        end
                    end
                end
`endif
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_dbg_loader.sv
// Self-checking bench for imem_dbg_loader: a reactive AHB-Lite slave model
// with configurable wait states and error injection, a byte-stream driver,
// and a reference model that predicts every word write from the byte stream.
module tb_imem_dbg_loader;

    localparam int AW = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] word_cnt = '0;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic [7:0]    byte_data = '0;
    logic          busy, done, err;
    logic [CW-1:0] words_written;
    logic [AW-1:0] HADDR;
    logic          HSEL, HREADY, HWRITE, HMASTLOCK;
    logic [2:0]    HSIZE, HBURST;
    logic [3:0]    HPROT;
    logic [1:0]    HTRANS;
    logic [31:0]   HWDATA;
    logic [31:0]   HRDATA = '0;
    logic          HREADYOUT = 1'b1;
    logic          HRESP = 1'b0;

    int checks = 0;
    int errors = 0;

    imem_dbg_loader #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .word_cnt(word_cnt), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .byte_data(byte_data), .busy(busy), .done(done), .err(err),
        .words_written(words_written),
        .imem_dbg_ahb_HADDR(HADDR), .imem_dbg_ahb_HSEL(HSEL),
        .imem_dbg_ahb_HREADY(HREADY), .imem_dbg_ahb_HWRITE(HWRITE),
        .imem_dbg_ahb_HSIZE(HSIZE), .imem_dbg_ahb_HBURST(HBURST),
        .imem_dbg_ahb_HPROT(HPROT), .imem_dbg_ahb_HTRANS(HTRANS),
        .imem_dbg_ahb_HMASTLOCK(HMASTLOCK), .imem_dbg_ahb_HWDATA(HWDATA),
        .imem_dbg_ahb_HRDATA(HRDATA), .imem_dbg_ahb_HREADYOUT(HREADYOUT),
        .imem_dbg_ahb_HRESP(HRESP)
    );

    always #5 clk = ~clk;

    // Slave model / monitor state
    int            waits = 0;
    int            err_at = -1;
    bit            rb_corrupt = 0;
    int            wr_idx = 0;
    bit            dph = 0;
    bit            dph_write = 0;
    logic [AW-1:0] dph_addr = '0;
    logic [31:0]   dph_data0 = '0;
    logic [AW-1:0] aph_addr0 = '0;
    logic          aph_w0 = 1'b0;
    int            pcnt = 0;
    int            cyc = 0;
    int            stab_err = 0;
    int            const_err = 0;
    int            rd_cnt = 0;
    int            done_cycles = 0;
    int            br_seen = 0;
    logic [AW-1:0] wq_addr[$];
    logic [31:0]   wq_data[$];
    int            wq_cyc[$];
    logic [31:0]   mem [logic [AW-1:0]];
    logic [7:0]    stim[$];

    // Reference model: word i is bytes 4i..4i+3 little-endian, written at the
    // word-aligned base plus 4i, modulo the address space.
    function automatic logic [31:0] exp_word(int i);
        return {stim[4*i+3], stim[4*i+2], stim[4*i+1], stim[4*i]};
    endfunction

    function automatic logic [AW-1:0] exp_addr(logic [AW-1:0] base, int i);
        int a;
        a = ((int'(base) / 4) * 4 + 4 * i) % (1 << AW);
        return a[AW-1:0];
    endfunction

    // Reactive AHB slave plus protocol monitor, evaluated mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            dph = 0;
            pcnt = 0;
            HREADYOUT = 1'b1;
            HRESP = 1'b0;
        end else begin
            if (HSIZE !== 3'b010 || HBURST !== 3'b000 || HPROT !== 4'b0011 ||
                HMASTLOCK !== 1'b0 || HREADY !== HREADYOUT)
                const_err++;
            if (byte_ready) br_seen++;
            if (done) done_cycles++;
            HRESP = 1'b0;
            HRDATA = $urandom;
            if (dph) begin
                if (pcnt == 0) dph_data0 = HWDATA;
                else if (dph_write && HWDATA !== dph_data0) stab_err++;
                if (HTRANS !== 2'b00) stab_err++;
                HREADYOUT = (pcnt >= waits);
                if (!dph_write)
                    HRDATA = rb_corrupt ? 32'hDEADBEEF :
                             (mem.exists(dph_addr) ? mem[dph_addr] : 32'h0);
                if (HREADYOUT) begin
                    if (dph_write) begin
                        if (err_at == wr_idx) HRESP = 1'b1;
                        else begin
                            wq_addr.push_back(dph_addr);
                            wq_data.push_back(HWDATA);
                            wq_cyc.push_back(cyc);
                            mem[dph_addr] = HWDATA;
                        end
                        wr_idx++;
                    end else begin
                        rd_cnt++;
                    end
                    dph = 0;
                    pcnt = 0;
                end else begin
                    pcnt++;
                end
            end else if (HSEL && HTRANS == 2'b10) begin
                if (pcnt == 0) begin
                    aph_addr0 = HADDR;
                    aph_w0 = HWRITE;
                end else if (HADDR !== aph_addr0 || HWRITE !== aph_w0) begin
                    stab_err++;
                end
                HREADYOUT = (pcnt >= waits);
                if (HREADYOUT) begin
                    dph = 1;
                    dph_addr = HADDR;
                    dph_write = HWRITE;
                    pcnt = 0;
                end else begin
                    pcnt++;
                end
            end else begin
                HREADYOUT = 1'b1;
                pcnt = 0;
            end
        end
    end

    task automatic prep(input int w);
        waits = w;
        err_at = -1;
        rb_corrupt = 0;
        wr_idx = 0;
        rd_cnt = 0;
        done_cycles = 0;
        br_seen = 0;
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
        stim.delete();
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [CW-1:0] n);
        @(negedge clk);
        start = 1'b1;
        base_addr = b;
        word_cnt = n;
        @(negedge clk);
        start = 1'b0;
        base_addr = $urandom;
        word_cnt = $urandom;
    endtask

    task automatic send_bytes(input int lo, input int hi, input bit nogap);
        for (int i = lo; i <= hi; i++) begin
            int t;
            if (!nogap) repeat ($urandom_range(0, 2)) @(negedge clk);
            byte_valid = 1'b1;
            byte_data = stim[i];
            t = 0;
            while (byte_ready !== 1'b1 && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) begin
                checks++;
                errors++;
                $display("FAIL byte_accept_timeout: byte %0d never accepted", i);
                byte_valid = 1'b0;
                return;
            end
            @(negedge clk);
            byte_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (done !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, t);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, err, byte_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: busy/done/err/byte_ready=%b required 0000", {busy, done, err, byte_ready});
        end
        checks++;
        if (words_written !== '0) begin
            errors++;
            $display("FAIL reset_ww: got %0d required 0", words_written);
        end
        checks++;
        if ({HSEL, HTRANS, HWRITE} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ahb_ctrl: HSEL/HTRANS/HWRITE=%b required 0000", {HSEL, HTRANS, HWRITE});
        end
        checks++;
        if (HADDR !== '0 || HWDATA !== '0) begin
            errors++;
            $display("FAIL reset_ahb_data: HADDR=%h HWDATA=%h required 0/0", HADDR, HWDATA);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int lat_exp;
`ifdef IMEM_DBG_LOADER_READBACK_EN
        lat_exp = 8;
`else
        lat_exp = 6;
`endif
        prep(0);
        stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        do_start(16'h0100, 16'd2);
        send_bytes(0, 7, 1'b1);
        wait_done();
        checks++;
        if (words_written !== 16'd2 || err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_status: ww=%0d err=%b busy=%b required 2/0/1", words_written, err, busy);
        end
        checks++;
        if (wq_addr.size() != 2) begin
            errors++;
            $display("FAIL basic_count: got %0d writes required 2", wq_addr.size());
        end else begin
            checks++;
            if (wq_addr[0] !== 16'h0100 || wq_data[0] !== 32'h44332211 ||
                wq_addr[1] !== 16'h0104 || wq_data[1] !== 32'h88776655) begin
                errors++;
                $display("FAIL basic_writes: %h@%h %h@%h required 44332211@0100 88776655@0104",
                         wq_data[0], wq_addr[0], wq_data[1], wq_addr[1]);
            end
            checks++;
            if (wq_cyc[1] - wq_cyc[0] != lat_exp) begin
                errors++;
                $display("FAIL basic_latency: got %0d cycles per word required %0d", wq_cyc[1] - wq_cyc[0], lat_exp);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || done_cycles != 1) begin
            errors++;
            $display("FAIL basic_done_pulse: done=%b busy=%b pulses=%0d required 0/0/1", done, busy, done_cycles);
        end
    endtask

    task automatic test_zero_count();
        prep(0);
        do_start(16'h0200, 16'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_done: done=%b busy=%b required 1/1", done, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || br_seen != 0 || wq_addr.size() != 0 || rd_cnt != 0) begin
            errors++;
            $display("FAIL zero_quiet: done=%b busy=%b byte_ready_cycles=%0d writes=%0d reads=%0d required 0/0/0/0/0",
                     done, busy, br_seen, wq_addr.size(), rd_cnt);
        end
    endtask

    task automatic test_wait_states();
        logic [AW-1:0] b;
        prep(3);
        b = AW'($urandom_range(0, 16'h3FFF) * 4);
        for (int i = 0; i < 8; i++) stim.push_back(8'($urandom));
        do_start(b, 16'd2);
        send_bytes(0, 7, 1'b0);
        wait_done();
        checks++;
        if (stab_err != 0) begin
            errors++;
            $display("FAIL wait_stability: got %0d unstable cycles required 0", stab_err);
        end
        checks++;
        if (wq_addr.size() != 2) begin
            errors++;
            $display("FAIL wait_count: got %0d writes required 2", wq_addr.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (wq_addr[i] !== exp_addr(b, i) || wq_data[i] !== exp_word(i)) begin
                    errors++;
                    $display("FAIL wait_write%0d: %h@%h required %h@%h", i, wq_data[i], wq_addr[i], exp_word(i), exp_addr(b, i));
                end
            end
        end
    endtask

    task automatic test_wrap();
        prep(0);
        for (int i = 0; i < 8; i++) stim.push_back(8'($urandom));
        do_start(16'hFFFC, 16'd2);
        send_bytes(0, 7, 1'b0);
        wait_done();
        checks++;
        if (wq_addr.size() != 2 || err !== 1'b0) begin
            errors++;
            $display("FAIL wrap_count: got %0d writes err=%b required 2/0", wq_addr.size(), err);
        end else begin
            checks++;
            if (wq_addr[0] !== 16'hFFFC || wq_addr[1] !== 16'h0000 ||
                wq_data[0] !== exp_word(0) || wq_data[1] !== exp_word(1)) begin
                errors++;
                $display("FAIL wrap_addr: %h@%h %h@%h required %h@fffc %h@0000",
                         wq_data[0], wq_addr[0], wq_data[1], wq_addr[1], exp_word(0), exp_word(1));
            end
        end
    endtask

    task automatic test_error();
        prep($urandom_range(0, 1));
        err_at = 0;
        for (int i = 0; i < 4; i++) stim.push_back(8'($urandom));
        do_start(16'h0400, 16'd3);
        send_bytes(0, 3, 1'b0);
        wait_done();
        checks++;
        if (err !== 1'b1 || words_written !== '0 || wq_addr.size() != 0) begin
            errors++;
            $display("FAIL error_resp: err=%b ww=%0d writes=%0d required 1/0/0", err, words_written, wq_addr.size());
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL error_sticky: err=%b busy=%b done=%b required 1/0/0", err, busy, done);
        end
        do_start(16'h0000, 16'd0);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL error_clear: err=%b after new start required 0", err);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        prep(0);
        for (int i = 0; i < 4; i++) stim.push_back(8'($urandom));
        do_start(16'h0800, 16'd2);
        send_bytes(0, 1, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, err, byte_ready, HSEL, HTRANS, HWRITE} !== 8'h00 ||
            words_written !== '0 || HADDR !== '0 || HWDATA !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: busy=%b done=%b err=%b br=%b HSEL=%b HTRANS=%b HWRITE=%b ww=%0d HADDR=%h HWDATA=%h required all 0",
                     busy, done, err, byte_ready, HSEL, HTRANS, HWRITE, words_written, HADDR, HWDATA);
        end
        reset = 1'b0;
        prep(0);
        for (int i = 0; i < 4; i++) stim.push_back(8'($urandom));
        do_start(16'h0900, 16'd1);
        send_bytes(0, 3, 1'b0);
        wait_done();
        checks++;
        if (wq_addr.size() != 1 || wq_addr[0] !== 16'h0900 || wq_data[0] !== exp_word(0)) begin
            errors++;
            $display("FAIL midreset_reload: writes=%0d first=%h@%h required 1 %h@0900",
                     wq_addr.size(), (wq_data.size() > 0) ? wq_data[0] : 32'h0,
                     (wq_addr.size() > 0) ? wq_addr[0] : 16'h0, exp_word(0));
        end
        @(negedge clk);
    endtask

    task automatic test_start_busy();
        prep(0);
        for (int i = 0; i < 4; i++) stim.push_back(8'($urandom));
        do_start(16'h0A00, 16'd1);
        send_bytes(0, 1, 1'b0);
        start = 1'b1;
        base_addr = 16'h0C00;
        word_cnt = 16'd5;
        @(negedge clk);
        start = 1'b0;
        send_bytes(2, 3, 1'b0);
        wait_done();
        checks++;
        if (wq_addr.size() != 1 || wq_addr[0] !== 16'h0A00 || wq_data[0] !== exp_word(0) || words_written !== 16'd1) begin
            errors++;
            $display("FAIL start_busy: writes=%0d ww=%0d required 1 write of %h@0a00, ww=1",
                     wq_addr.size(), words_written, exp_word(0));
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            logic [AW-1:0] b;
            int n;
            int rd_exp;
            prep($urandom_range(0, 2));
            b = AW'($urandom);
            n = $urandom_range(1, 4);
            for (int i = 0; i < 4 * n; i++) stim.push_back(8'($urandom));
`ifdef IMEM_DBG_LOADER_READBACK_EN
            rd_exp = n;
`else
            rd_exp = 0;
`endif
            do_start(b, CW'(n));
            send_bytes(0, 4 * n - 1, 1'b0);
            wait_done();
            checks++;
            if (wq_addr.size() != n || words_written !== CW'(n) || err !== 1'b0 || rd_cnt != rd_exp) begin
                errors++;
                $display("FAIL rand%0d_status: writes=%0d ww=%0d err=%b reads=%0d required %0d/%0d/0/%0d",
                         it, wq_addr.size(), words_written, err, rd_cnt, n, n, rd_exp);
            end else begin
                for (int i = 0; i < n; i++) begin
                    checks++;
                    if (wq_addr[i] !== exp_addr(b, i) || wq_data[i] !== exp_word(i)) begin
                        errors++;
                        $display("FAIL rand%0d_write%0d: %h@%h required %h@%h",
                                 it, i, wq_data[i], wq_addr[i], exp_word(i), exp_addr(b, i));
                    end
                end
            end
            @(negedge clk);
        end
    endtask

`ifdef IMEM_DBG_LOADER_READBACK_EN
    task automatic test_readback();
        prep(0);
        rb_corrupt = 1;
        stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        do_start(16'h0100, 16'd2);
        send_bytes(0, 3, 1'b0);
        wait_done();
        checks++;
        if (err !== 1'b1 || wq_addr.size() != 1 || rd_cnt != 1 || words_written !== 16'd1) begin
            errors++;
            $display("FAIL readback_mismatch: err=%b writes=%0d reads=%0d ww=%0d required 1/1/1/1",
                     err, wq_addr.size(), rd_cnt, words_written);
        end
        @(negedge clk);
    endtask
`endif

    task automatic test_constants();
        checks++;
        if (const_err != 0 || stab_err != 0) begin
            errors++;
            $display("FAIL constants: %0d constant-signal violations, %0d stability violations, required 0/0",
                     const_err, stab_err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_count();
        test_wait_states();
        test_wrap();
        test_error();
        test_reset_mid();
        test_start_busy();
        test_random();
`ifdef IMEM_DBG_LOADER_READBACK_EN
        test_readback();
`endif
        test_constants();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
